fb_frame_scheduler: RTL and testbench
=====================================

Name: fb_frame_scheduler

Overview:
- Per-frame sequencer and write-port arbiter for the 160x120, 12-bit-colour frame buffer.
- Each frame period it runs the clear engine, then the trace (sine) engine, each on its own start/done handshake, and muxes the granted engine's pixel stream onto one registered write port.
- It also snapshots the ADC word for the trace engine and flags frames that overrun the period.

Parameters:
- FRAME_CYCLES, 500000, clk cycles per frame period (50 Hz at 25 MHz); simulation uses 64.
- CW, 12, colour width.
- AW, 8, X/Y coordinate width.
- DW, 14, ADC sample width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- man_in  in  1  pause; while 1, no new frame is started (a running frame completes).
- adc  in  DW  live ADC sample.
- clr_start  out  1  one-cycle start pulse to the clear engine.
- clr_x, clr_y  in  AW each  clear engine pixel coordinates.
- clr_color  in  CW  clear engine pixel colour.
- clr_valid  in  1  clear engine pixel valid.
- clr_done  in  1  clear engine finished (may coincide with the last clr_valid).
- trc_start  out  1  one-cycle start pulse to the trace engine.
- trc_x, trc_y  in  AW each  trace engine pixel coordinates.
- trc_color  in  CW  trace engine pixel colour.
- trc_valid  in  1  trace engine pixel valid.
- trc_done  in  1  trace engine finished.
- adc_snap  out  DW  ADC value frozen for the current trace.
- fb_x, fb_y  out  AW each  frame-buffer write address.
- fb_color  out  CW  frame-buffer write data.
- fb_we  out  1  frame-buffer write enable.
- busy  out  1  high in CLEAR or TRACE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_count  out  16  completed frames, wraps at 65535 to 0.
- overrun  out  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset: all outputs 0, state IDLE, period counter fc=0. No tri-state values are ever driven.
- Period counter fc:
  - Increments every non-reset cycle and wraps from FRAME_CYCLES-1 to 0.
  - tick = (fc==0), so the first tick is the first edge after rst falls.
- States: IDLE, CLEAR, TRACE, WAIT.
- IDLE/WAIT:
  - On an edge with tick=1 and man_in=0: go to CLEAR and register clr_start=1 for exactly one cycle.
  - Tick with man_in=1: stay put, no pulse, no overrun.
- CLEAR:
  - Each edge registers fb_x/fb_y/fb_color <= clr_*, and fb_we <= clr_valid. Latency is 1 cycle.
  - On an edge with clr_done=1: go to TRACE, pulse trc_start, adc_snap <= adc.
  - A clr_valid in the same cycle as clr_done is still written.
- TRACE:
  - Same mux rule using trc_*.
  - On trc_done: go to WAIT, pulse frame_done, frame_count += 1. A coincident trc_valid is written.
- Non-granted channel: its valid is ignored and never produces fb_we. In IDLE/WAIT, fb_we=0; fb_x/fb_y/fb_color hold their last values.
- adc_snap changes only on CLEAR->TRACE; it is stable for the whole trace.
- Overrun:
  - A tick while in CLEAR or TRACE sets overrun (cleared only by rst) and does not restart or abort the current frame.
  - The next frame begins at the next tick seen in WAIT.
- man_in going high mid-frame has no effect on the running frame.
- rst mid-frame: state returns to IDLE on that edge, start pulses and fb_we go 0, the frame is not counted. Engines share rst.
- busy is registered: it is 1 on the cycle after entering CLEAR through the cycle of the TRACE->WAIT edge.

Test Plan:
1. Nominal frame (FRAME_CYCLES=64):
   - Stimulus: release rst; clear model emits 10 valid pixels (x=0..9, y=0, colour 12'h000) then clr_done; trace model emits 4 pixels (colour 12'hF00) then trc_done.
   - Required response: clr_start high on cycle 1 only; exactly 14 fb_we cycles, each matching its source one cycle later; frame_done once; frame_count=1; overrun=0.
2. Periodic restart:
   - Stimulus: run 3 periods with short engines.
   - Required response: clr_start pulses at fc=0 edges spaced exactly 64 cycles; frame_count=3.
3. Overrun:
   - Stimulus: clear model holds clr_done low for 70 cycles.
   - Required response: overrun=1 at cycle 64; no second clr_start until the first tick after WAIT (cycle 128); frame_count=1 after completion.
4. Pause:
   - Stimulus: man_in=1 across a tick while in WAIT.
   - Required response: no clr_start; man_in=1 raised during TRACE still allows that frame to finish with frame_done.
5. ADC snapshot and isolation:
   - Stimulus: adc=14'h1234 at the trc_start edge, then changed to 14'h3FFF during TRACE; assert clr_valid during TRACE.
   - Required response: adc_snap stays 14'h1234; no fb_we from the clr channel.
6. Reset mid-trace:
   - Stimulus: assert rst for 1 cycle during TRACE.
   - Required response: all outputs 0 next cycle, frame_count unchanged (0 if first frame), new clr_start on the first edge after release.

Source files
------------

// File: rtl/fb_frame_scheduler.sv
// fb_frame_scheduler: per-frame clear/trace sequencer and frame-buffer write arbiter
module fb_frame_scheduler #(
   parameter int FRAME_CYCLES = 500000,
   parameter int CW = 12,
   parameter int AW = 8,
   parameter int DW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          man_in,
   input  logic [DW-1:0] adc,
   output logic          clr_start,
   input  logic [AW-1:0] clr_x,
   input  logic [AW-1:0] clr_y,
   input  logic [CW-1:0] clr_color,
   input  logic          clr_valid,
   input  logic          clr_done,
   output logic          trc_start,
   input  logic [AW-1:0] trc_x,
   input  logic [AW-1:0] trc_y,
   input  logic [CW-1:0] trc_color,
   input  logic          trc_valid,
   input  logic          trc_done,
   output logic [DW-1:0] adc_snap,
   output logic [AW-1:0] fb_x,
   output logic [AW-1:0] fb_y,
   output logic [CW-1:0] fb_color,
   output logic          fb_we,
   output logic          busy,
   output logic          frame_done,
   output logic [15:0]   frame_count,
   output logic          overrun
);

   localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_TRACE, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [FW-1:0] r_fc;
   logic          w_tick;
   logic          w_clr_go;
   logic          w_trc_go;
   logic          w_frm_go;
   logic          w_sel_clr;
   logic          w_sel_trc;

   // next-state and start/done pulse decode; a tick only launches a frame from IDLE/WAIT
   always_comb begin
      w_tick    = (r_fc == '0);
      w_sel_clr = (r_state == S_CLEAR);
      w_sel_trc = (r_state == S_TRACE);
      w_next    = r_state;
      w_clr_go  = 1'b0;
      w_trc_go  = 1'b0;
      w_frm_go  = 1'b0;
      case (r_state)
         S_IDLE, S_WAIT: begin
            if (w_tick && !man_in) begin
               w_next   = S_CLEAR;
               w_clr_go = 1'b1;
            end
         end
         S_CLEAR: begin
            if (clr_done) begin
               w_next   = S_TRACE;
               w_trc_go = 1'b1;
            end
         end
         S_TRACE: begin
            if (trc_done) begin
               w_next   = S_WAIT;
               w_frm_go = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // state register and free-running frame period counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_fc    <= '0;
      end else begin
         r_state <= w_next;
         r_fc    <= (r_fc == FW'(FRAME_CYCLES - 1)) ? '0 : r_fc + FW'(1);
      end
   end

   // registered outputs: pulses, write-port mux, ADC snapshot, frame counter, sticky overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_start   <= 1'b0;
         trc_start   <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         fb_we       <= 1'b0;
         fb_x        <= '0;
         fb_y        <= '0;
         fb_color    <= '0;
         adc_snap    <= '0;
         frame_count <= '0;
         overrun     <= 1'b0;
      end else begin
         clr_start  <= w_clr_go;
         trc_start  <= w_trc_go;
         frame_done <= w_frm_go;
         busy       <= (w_next == S_CLEAR) || (w_next == S_TRACE);
         fb_we      <= (w_sel_clr && clr_valid) || (w_sel_trc && trc_valid);
         if (w_sel_clr || w_sel_trc) begin
            fb_x     <= w_sel_clr ? clr_x : trc_x;
            fb_y     <= w_sel_clr ? clr_y : trc_y;
            fb_color <= w_sel_clr ? clr_color : trc_color;
         end
         if (w_trc_go) adc_snap <= adc;
         if (w_frm_go) frame_count <= frame_count + 16'd1;
         if (w_tick && (w_sel_clr || w_sel_trc)) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fb_frame_scheduler.sv
// tb_fb_frame_scheduler: scoreboard bench for the frame scheduler with behavioural clear/trace engines
module tb_fb_frame_scheduler;

   logic        clk;
   logic        rst;
   logic        man_in;
   logic [13:0] adc;
   logic        clr_start;
   logic [7:0]  clr_x;
   logic [7:0]  clr_y;
   logic [11:0] clr_color;
   logic        clr_valid;
   logic        clr_done;
   logic        trc_start;
   logic [7:0]  trc_x;
   logic [7:0]  trc_y;
   logic [11:0] trc_color;
   logic        trc_valid;
   logic        trc_done;
   logic [13:0] adc_snap;
   logic [7:0]  fb_x;
   logic [7:0]  fb_y;
   logic [11:0] fb_color;
   logic        fb_we;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        overrun;

   logic [27:0] q[$];
   logic [63:0] all_out;
   int          n_chk;
   int          n_pass;
   int          n_wr;
   int          n_fd;
   int          nfr;
   int          cyc;
   int          st;
   int          prev;

   fb_frame_scheduler #(.FRAME_CYCLES(64), .CW(12), .AW(8), .DW(14)) dut (
      .clk(clk), .rst(rst), .man_in(man_in), .adc(adc),
      .clr_start(clr_start), .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color),
      .clr_valid(clr_valid), .clr_done(clr_done),
      .trc_start(trc_start), .trc_x(trc_x), .trc_y(trc_y), .trc_color(trc_color),
      .trc_valid(trc_valid), .trc_done(trc_done),
      .adc_snap(adc_snap), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_we(fb_we),
      .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .overrun(overrun)
   );

   assign all_out = {clr_start, trc_start, fb_we, busy, frame_done, overrun,
                     frame_count, adc_snap, fb_x, fb_y, fb_color};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle index: edge k after reset release leaves cyc == k
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // every frame-buffer write must match the oldest pending expected pixel
   always @(negedge clk) begin
      if (frame_done) n_fd++;
      if (fb_we) begin
         n_wr++;
         if (q.size() == 0) chk("fb_spurious", 64'(fb_we), 64'd0);
         else chk("fb_px", 64'({fb_x, fb_y, fb_color}), 64'(q.pop_front()));
      end
   end

   task automatic wait_start(input int bound, output int at);
      at = -1;
      for (int k = 0; k < bound; k++) begin
         step();
         if (clr_start) begin
            at = cyc;
            break;
         end
      end
      chk("start_seen", 64'(at >= 0), 64'd1);
   endtask

   task automatic do_frame(input int hold, input int nc, input int nt, input logic noise,
                           input logic pause, input logic [13:0] av, input int s);
      for (int h = 0; h < hold; h++) begin
         clr_valid = 1'b0;
         step();
         chk("ovr_hold", 64'({overrun, clr_start}), (cyc - s >= 64) ? 64'd2 : 64'd0);
      end
      for (int i = 0; i < nc; i++) begin
         clr_valid = 1'b1;
         clr_x     = 8'(i);
         clr_y     = 8'(nfr);
         clr_color = 12'(nfr);
         clr_done  = (i == nc - 1);
         if (i == nc - 1) adc = av;
         q.push_back({8'(i), 8'(nfr), 12'(nfr)});
         step();
         if (i == 0 && hold == 0) chk("clr_pulse_busy", 64'({clr_start, busy}), 64'd1);
      end
      clr_valid = 1'b0;
      clr_done  = 1'b0;
      chk("trc_start", 64'(trc_start), 64'd1);
      chk("snap", 64'(adc_snap), 64'(av));
      if (noise) adc = 14'h3FFF;
      if (pause) man_in = 1'b1;
      for (int i = 0; i < nt; i++) begin
         trc_valid = 1'b1;
         trc_x     = 8'(100 + i);
         trc_y     = 8'(nfr + 50);
         trc_color = 12'hF00 | 12'(nfr);
         trc_done  = (i == nt - 1);
         clr_valid = noise;
         clr_x     = 8'hEE;
         q.push_back({8'(100 + i), 8'(nfr + 50), 12'hF00 | 12'(nfr)});
         step();
         chk("snap_hold", 64'(adc_snap), 64'(av));
      end
      trc_valid = 1'b0;
      trc_done  = 1'b0;
      clr_valid = 1'b0;
      nfr++;
      chk("frame_done", 64'({frame_done, busy}), 64'd2);
      chk("frame_cnt", 64'(frame_count), 64'(nfr));
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_wr = 0; n_fd = 0; nfr = 0; cyc = 0;
      rst = 1'b1; man_in = 1'b0; adc = '0;
      clr_x = '0; clr_y = '0; clr_color = '0; clr_valid = 1'b0; clr_done = 1'b0;
      trc_x = '0; trc_y = '0; trc_color = '0; trc_valid = 1'b0; trc_done = 1'b0;
      repeat (3) step();
      chk("reset_out", all_out, 64'd0);
      rst = 1'b0;
      wait_start(4, st);
      chk("start_c1", 64'(st), 64'd1);
      do_frame(0, 10, 4, 1'b0, 1'b0, 14'h00AB, st);
      step();
      chk("wr_cnt", 64'(n_wr), 64'd14);
      chk("fd_cnt1", 64'(n_fd), 64'd1);
      chk("no_ovr", 64'(overrun), 64'd0);
      for (int f = 0; f < 2; f++) begin
         prev = st;
         wait_start(80, st);
         chk("period", 64'(st - prev), 64'd64);
         do_frame(0, 3, 2, 1'b0, 1'b0, 14'(f + 16'h111), st);
      end
      chk("fc3", 64'(frame_count), 64'd3);
      prev = st;
      wait_start(80, st);
      chk("period_ov", 64'(st - prev), 64'd64);
      do_frame(70, 3, 2, 1'b0, 1'b0, 14'h0222, st);
      chk("ovr_set", 64'(overrun), 64'd1);
      prev = st;
      wait_start(140, st);
      chk("ovr_gap", 64'(st - prev), 64'd128);
      do_frame(0, 2, 2, 1'b0, 1'b1, 14'h0333, st);
      for (int k = 0; k < 70; k++) begin
         step();
         chk("pause_nostart", 64'(clr_start), 64'd0);
      end
      man_in = 1'b0;
      prev = st;
      wait_start(80, st);
      chk("pause_gap", 64'(st - prev), 64'd128);
      do_frame(0, 3, 4, 1'b1, 1'b0, 14'h1234, st);
      step();
      chk("fd_cnt6", 64'(n_fd), 64'd6);
      chk("q_empty", 64'(q.size()), 64'd0);
      rst = 1'b1;
      repeat (2) step();
      chk("reset2_out", all_out, 64'd0);
      rst = 1'b0;
      wait_start(4, st);
      chk("start2_c1", 64'(st), 64'd1);
      clr_valid = 1'b1; clr_x = 8'd1; clr_y = 8'h55; clr_color = 12'h0AA; clr_done = 1'b1;
      q.push_back({8'd1, 8'h55, 12'h0AA});
      step();
      clr_valid = 1'b0; clr_done = 1'b0;
      chk("trc_start2", 64'(trc_start), 64'd1);
      trc_valid = 1'b1; trc_x = 8'd3; trc_y = 8'd4; trc_color = 12'h5A5;
      q.push_back({8'd3, 8'd4, 12'h5A5});
      step();
      rst = 1'b1;
      step();
      chk("rst_mid", all_out, 64'd0);
      rst = 1'b0;
      trc_valid = 1'b0;
      step();
      chk("restart", 64'({clr_start, 8'(cyc)}), 64'h101);
      step();
      chk("q_empty2", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
